// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants and code-layout helpers for the Hamming codec.
// Position p (1-based) of the Hamming word is code bit p-1; parity bits sit at
// power-of-two positions, data bits fill the rest in ascending order.
package hamming_pkg;

   // Highest Hamming position considered by the layout helpers (57 data + 6 parity).
   localparam int MAX_POS = 64;

   // Smallest r with 2^r >= data_w + r + 1.
   function automatic int calc_par_w(input int data_w);
      int r;
      r = 1;
      for (int i = 0; i < 8; i++) begin
         if ((1 << r) < (data_w + r + 1)) r = r + 1;
      end
      return r;
   endfunction

   // True for parity positions (1, 2, 4, 8, ...).
   function automatic bit is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // 1-based Hamming position that carries data bit idx.
   function automatic int data_pos(input int idx);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 1; p < MAX_POS; p++) begin
         if (!is_pow2(p)) begin
            if ((cnt == idx) && (res == 0)) res = p;
            cnt = cnt + 1;
         end
      end
      return res;
   endfunction

   // Data bit index carried by a non-parity Hamming position.
   function automatic int data_idx(input int pos);
      int cnt;
      cnt = 0;
      for (int p = 1; p < MAX_POS; p++) begin
         if ((p < pos) && !is_pow2(p)) cnt = cnt + 1;
      end
      return cnt;
   endfunction

   // Code-bit mask of every position whose index has any bit of sel set.
   function automatic logic [MAX_POS-1:0] cover_mask(input int sel);
      logic [MAX_POS-1:0] m;
      m = '0;
      for (int p = 1; p < MAX_POS; p++) begin
         m[p-1] = ((p & sel) != 0);
      end
      return m;
   endfunction

endpackage

// File: rtl/hamming_pipe_reg.sv
// hamming_pipe_reg: one-deep valid/ready register stage. Accepts a new word
// whenever it is empty or being drained in the same cycle, so it sustains one
// word per cycle while out_ready stays high.
module hamming_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_reg;
   logic [WIDTH-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   // Load on handshake, otherwise drop the word once the consumer takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (in_valid && in_ready) begin
         valid_reg <= 1'b1;
         data_reg  <= in_data;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/hamming_codec.sv
// hamming_codec: parametrised Hamming encoder and syndrome decoder with
// single-bit correction and saturating error counters. Each path is one
// registered valid/ready stage; the two paths are independent.
// Define HAMMING_SECDED_EN to append an overall parity bit (SECDED mode).
module hamming_codec
   import hamming_pkg::*;
#(
   parameter int  DATA_W = 4,
   parameter int  CNT_W  = 16,
   localparam int PAR_W  = calc_par_w(DATA_W),
   localparam int HAM_W  = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
   localparam int CODE_W = HAM_W + 1
`else
   localparam int CODE_W = HAM_W
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enc_in_valid,
   output logic              enc_in_ready,
   input  logic [DATA_W-1:0] enc_in_data,
   output logic              enc_out_valid,
   input  logic              enc_out_ready,
   output logic [CODE_W-1:0] enc_out_code,
   input  logic              dec_in_valid,
   output logic              dec_in_ready,
   input  logic [CODE_W-1:0] dec_in_code,
   output logic              dec_out_valid,
   input  logic              dec_out_ready,
   output logic [DATA_W-1:0] dec_out_data,
   output logic [PAR_W-1:0]  dec_out_syndrome,
   output logic              dec_out_corrected,
   output logic              dec_out_uncorr,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   localparam int DEC_PW = DATA_W + PAR_W + 2;

   // ---------------- encoder ----------------
   // enc_spread holds the data bits at their positions with zeros at parity slots.
   logic [HAM_W-1:0]  enc_spread;
   logic [HAM_W-1:0]  enc_ham;
   logic [CODE_W-1:0] enc_code;

   genvar gi;
   generate
      for (gi = 1; gi <= HAM_W; gi++) begin : g_enc
         if (is_pow2(gi)) begin : g_par
            localparam logic [MAX_POS-1:0] MASK = cover_mask(gi);
            assign enc_spread[gi-1] = 1'b0;
            assign enc_ham[gi-1]    = ^(enc_spread & MASK[HAM_W-1:0]);
         end else begin : g_dat
            assign enc_spread[gi-1] = enc_in_data[data_idx(gi)];
            assign enc_ham[gi-1]    = enc_spread[gi-1];
         end
      end
   endgenerate

`ifdef HAMMING_SECDED_EN
   assign enc_code = {^enc_ham, enc_ham};
`else
   assign enc_code = enc_ham;
`endif

   hamming_pipe_reg #(.WIDTH(CODE_W)) u_enc_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (enc_in_valid),
      .in_ready  (enc_in_ready),
      .in_data   (enc_code),
      .out_valid (enc_out_valid),
      .out_ready (enc_out_ready),
      .out_data  (enc_out_code)
   );

   // ---------------- decoder ----------------
   logic [HAM_W-1:0]  dec_ham;
   logic [HAM_W-1:0]  dec_fixed;
   logic [PAR_W-1:0]  dec_syn;
   logic [DATA_W-1:0] dec_data;
   logic              syn_nz;
   logic              syn_in_range;
   logic              flip_en;
   logic              dec_corr;
   logic              dec_unc;
   logic              dec_load;
   logic [DEC_PW-1:0] dec_payload;
   logic [DEC_PW-1:0] dec_out_payload;

   assign dec_ham = dec_in_code[HAM_W-1:0];

   // Syndrome bit k is the parity of every position with bit k set, which
   // equals the XOR of the positions of all set code bits.
   generate
      for (gi = 0; gi < PAR_W; gi++) begin : g_syn
         localparam logic [MAX_POS-1:0] MASK = cover_mask(1 << gi);
         assign dec_syn[gi] = ^(dec_ham & MASK[HAM_W-1:0]);
      end
   endgenerate

   assign syn_nz       = |dec_syn;
   assign syn_in_range = syn_nz && (int'(dec_syn) <= HAM_W);

`ifdef HAMMING_SECDED_EN
   logic ovr_mis;
   // An odd number of flipped bits shows as an overall parity mismatch.
   assign ovr_mis  = ^dec_in_code;
   assign flip_en  = syn_in_range && ovr_mis;
   assign dec_corr = ovr_mis && (syn_in_range || !syn_nz);
   assign dec_unc  = syn_nz && !flip_en;
`else
   assign flip_en  = syn_in_range;
   assign dec_corr = syn_in_range;
   assign dec_unc  = syn_nz && !syn_in_range;
`endif

   // Flip the code bit the syndrome points at; uncorrectable words pass raw.
   always_comb begin
      dec_fixed = dec_ham;
      for (int p = 1; p <= HAM_W; p++) begin
         if (flip_en && (int'(dec_syn) == p)) dec_fixed[p-1] = ~dec_ham[p-1];
      end
   end

   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_ext
         localparam int POS = data_pos(gi);
         assign dec_data[gi] = dec_fixed[POS-1];
      end
   endgenerate

   assign dec_payload = {dec_unc, dec_corr, dec_syn, dec_data};

   hamming_pipe_reg #(.WIDTH(DEC_PW)) u_dec_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (dec_in_valid),
      .in_ready  (dec_in_ready),
      .in_data   (dec_payload),
      .out_valid (dec_out_valid),
      .out_ready (dec_out_ready),
      .out_data  (dec_out_payload)
   );

   assign dec_out_data      = dec_out_payload[DATA_W-1:0];
   assign dec_out_syndrome  = dec_out_payload[DATA_W +: PAR_W];
   assign dec_out_corrected = dec_out_payload[DEC_PW-2];
   assign dec_out_uncorr    = dec_out_payload[DEC_PW-1];

   // ---------------- statistics ----------------
   logic [CNT_W-1:0] corr_cnt_reg;
   logic [CNT_W-1:0] uncorr_cnt_reg;

   assign dec_load   = dec_in_valid && dec_in_ready;
   assign corr_cnt   = corr_cnt_reg;
   assign uncorr_cnt = uncorr_cnt_reg;

   // Count flagged decoder loads, saturating; a clear wins over an increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         corr_cnt_reg   <= '0;
         uncorr_cnt_reg <= '0;
      end else if (cnt_clr) begin
         corr_cnt_reg   <= '0;
         uncorr_cnt_reg <= '0;
      end else begin
         if (dec_load && dec_corr && (corr_cnt_reg != {CNT_W{1'b1}}))
            corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
         if (dec_load && dec_unc && (uncorr_cnt_reg != {CNT_W{1'b1}}))
            uncorr_cnt_reg <= uncorr_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_codec.sv
// tb_hamming_codec: directed checks of the Hamming codec. Instance A uses
// DATA_W=4 with 2-bit counters; instance B uses DATA_W=5 for an
// out-of-range syndrome and the mid-operation reset.
module tb_hamming_codec;

`ifdef HAMMING_SECDED_EN
   localparam int SD = 1;
`else
   localparam int SD = 0;
`endif
   localparam int CWA = 7 + SD;
   localparam int CWB = 9 + SD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic           enc_in_valid_a, enc_in_ready_a, enc_out_valid_a, enc_out_ready_a;
   logic [3:0]     enc_in_data_a;
   logic [CWA-1:0] enc_out_code_a;
   logic           dec_in_valid_a, dec_in_ready_a, dec_out_valid_a, dec_out_ready_a;
   logic [CWA-1:0] dec_in_code_a;
   logic [3:0]     dec_out_data_a;
   logic [2:0]     dec_out_syndrome_a;
   logic           dec_out_corrected_a, dec_out_uncorr_a, cnt_clr_a;
   logic [1:0]     corr_cnt_a, uncorr_cnt_a;

   logic           enc_in_valid_b, enc_in_ready_b, enc_out_valid_b, enc_out_ready_b;
   logic [4:0]     enc_in_data_b;
   logic [CWB-1:0] enc_out_code_b;
   logic           dec_in_valid_b, dec_in_ready_b, dec_out_valid_b, dec_out_ready_b;
   logic [CWB-1:0] dec_in_code_b;
   logic [4:0]     dec_out_data_b;
   logic [3:0]     dec_out_syndrome_b;
   logic           dec_out_corrected_b, dec_out_uncorr_b, cnt_clr_b;
   logic [15:0]    corr_cnt_b, uncorr_cnt_b;

   int checks = 0;
   int errors = 0;

   hamming_codec #(.DATA_W(4), .CNT_W(2)) u_dut_a (
      .clk(clk), .reset(reset),
      .enc_in_valid(enc_in_valid_a), .enc_in_ready(enc_in_ready_a), .enc_in_data(enc_in_data_a),
      .enc_out_valid(enc_out_valid_a), .enc_out_ready(enc_out_ready_a), .enc_out_code(enc_out_code_a),
      .dec_in_valid(dec_in_valid_a), .dec_in_ready(dec_in_ready_a), .dec_in_code(dec_in_code_a),
      .dec_out_valid(dec_out_valid_a), .dec_out_ready(dec_out_ready_a), .dec_out_data(dec_out_data_a),
      .dec_out_syndrome(dec_out_syndrome_a), .dec_out_corrected(dec_out_corrected_a),
      .dec_out_uncorr(dec_out_uncorr_a), .cnt_clr(cnt_clr_a),
      .corr_cnt(corr_cnt_a), .uncorr_cnt(uncorr_cnt_a)
   );

   hamming_codec #(.DATA_W(5), .CNT_W(16)) u_dut_b (
      .clk(clk), .reset(reset),
      .enc_in_valid(enc_in_valid_b), .enc_in_ready(enc_in_ready_b), .enc_in_data(enc_in_data_b),
      .enc_out_valid(enc_out_valid_b), .enc_out_ready(enc_out_ready_b), .enc_out_code(enc_out_code_b),
      .dec_in_valid(dec_in_valid_b), .dec_in_ready(dec_in_ready_b), .dec_in_code(dec_in_code_b),
      .dec_out_valid(dec_out_valid_b), .dec_out_ready(dec_out_ready_b), .dec_out_data(dec_out_data_b),
      .dec_out_syndrome(dec_out_syndrome_b), .dec_out_corrected(dec_out_corrected_b),
      .dec_out_uncorr(dec_out_uncorr_b), .cnt_clr(cnt_clr_b),
      .corr_cnt(corr_cnt_b), .uncorr_cnt(uncorr_cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // Append the overall parity bit when SECDED is compiled in.
   function automatic logic [CWA-1:0] ext_a(input logic [6:0] c);
      logic [7:0] t;
      t = {^c, c};
      if (SD == 0) t[7] = 1'b0;
      return t[CWA-1:0];
   endfunction

   function automatic logic [CWB-1:0] ext_b(input logic [8:0] c);
      logic [9:0] t;
      t = {^c, c};
      if (SD == 0) t[9] = 1'b0;
      return t[CWB-1:0];
   endfunction

   task automatic dec_a(input logic [CWA-1:0] code, input logic clr);
      @(negedge clk);
      dec_in_valid_a = 1'b1;
      dec_in_code_a  = code;
      cnt_clr_a      = clr;
      @(negedge clk);
      dec_in_valid_a = 1'b0;
      cnt_clr_a      = 1'b0;
      $display("dec_a in=%0h data=%0h syn=%0d corr=%0b unc=%0b cnt=%0d/%0d", code,
               dec_out_data_a, dec_out_syndrome_a, dec_out_corrected_a, dec_out_uncorr_a,
               corr_cnt_a, uncorr_cnt_a);
   endtask

   logic [CWA-1:0] va;
   logic [CWB-1:0] vb;

   initial begin
      reset = 1'b1;
      enc_in_valid_a = 0; enc_in_data_a = '0; enc_out_ready_a = 1;
      dec_in_valid_a = 0; dec_in_code_a = '0; dec_out_ready_a = 1; cnt_clr_a = 0;
      enc_in_valid_b = 0; enc_in_data_b = '0; enc_out_ready_b = 1;
      dec_in_valid_b = 0; dec_in_code_b = '0; dec_out_ready_b = 1; cnt_clr_b = 0;
      repeat (2) @(negedge clk);
      chk("rst_enc_valid", 32'(enc_out_valid_a), 0);
      chk("rst_dec_valid", 32'(dec_out_valid_a), 0);
      chk("rst_enc_code", 32'(enc_out_code_a), 0);
      chk("rst_dec_data", 32'(dec_out_data_a), 0);
      chk("rst_corr_cnt", 32'(corr_cnt_a), 0);
      chk("rst_enc_ready", 32'(enc_in_ready_a), 1);
      reset = 1'b0;

      // Encode 1011 -> 1010101 one cycle later.
      @(negedge clk); enc_in_valid_a = 1; enc_in_data_a = 4'b1011;
      @(negedge clk); enc_in_valid_a = 0;
      $display("enc_a data=1011 code=%0h", enc_out_code_a);
      chk("enc_1011_valid", 32'(enc_out_valid_a), 1);
      chk("enc_1011", 32'(enc_out_code_a), 32'(ext_a(7'b1010101)));

      // Back-to-back encodes at full throughput.
      @(negedge clk);
      chk("enc_drained", 32'(enc_out_valid_a), 0);
      enc_in_valid_a = 1; enc_in_data_a = 4'b1111;
      @(negedge clk); enc_in_data_a = 4'b0110;
      $display("enc_a data=1111 code=%0h", enc_out_code_a);
      chk("enc_1111", 32'(enc_out_code_a), 32'(ext_a(7'b1111111)));
      @(negedge clk); enc_in_valid_a = 0;
      $display("enc_a data=0110 code=%0h", enc_out_code_a);
      chk("enc_0110", 32'(enc_out_code_a), 32'(ext_a(7'b0110011)));
      chk("enc_b2b_valid", 32'(enc_out_valid_a), 1);

      // Backpressure: second word waits while the first is held.
      @(negedge clk); enc_out_ready_a = 0; enc_in_valid_a = 1; enc_in_data_a = 4'b0001;
      @(negedge clk); enc_in_data_a = 4'b0110;
      chk("bp_ready_low", 32'(enc_in_ready_a), 0);
      chk("bp_first", 32'(enc_out_code_a), 32'(ext_a(7'b0000111)));
      @(negedge clk);
      $display("enc_a held code=%0h ready=%0b", enc_out_code_a, enc_in_ready_a);
      chk("bp_hold", 32'(enc_out_code_a), 32'(ext_a(7'b0000111)));
      chk("bp_ready_still_low", 32'(enc_in_ready_a), 0);
      enc_out_ready_a = 1;
      @(negedge clk); enc_in_valid_a = 0;
      $display("enc_a released code=%0h", enc_out_code_a);
      chk("bp_second", 32'(enc_out_code_a), 32'(ext_a(7'b0110011)));
      chk("bp_second_valid", 32'(enc_out_valid_a), 1);
      @(negedge clk);
      chk("bp_drained", 32'(enc_out_valid_a), 0);

      // Decoder: clean word, then single-bit errors.
      dec_a(ext_a(7'b1010101), 1'b0);
      chk("dec_clean_data", 32'(dec_out_data_a), 'hb);
      chk("dec_clean_syn", 32'(dec_out_syndrome_a), 0);
      chk("dec_clean_corr", 32'(dec_out_corrected_a), 0);
      chk("dec_clean_cnt", 32'(corr_cnt_a), 0);

      va = ext_a(7'b1010101); va[4] = ~va[4];
      dec_a(va, 1'b0);
      chk("dec_b4_valid", 32'(dec_out_valid_a), 1);
      chk("dec_b4_data", 32'(dec_out_data_a), 'hb);
      chk("dec_b4_syn", 32'(dec_out_syndrome_a), 5);
      chk("dec_b4_corr", 32'(dec_out_corrected_a), 1);
      chk("dec_b4_unc", 32'(dec_out_uncorr_a), 0);
      chk("dec_b4_cnt", 32'(corr_cnt_a), 1);

      va = ext_a(7'b0000111); va[0] = ~va[0];
      dec_a(va, 1'b0);
      chk("dec_b0_data", 32'(dec_out_data_a), 'h1);
      chk("dec_b0_syn", 32'(dec_out_syndrome_a), 1);
      chk("dec_b0_cnt", 32'(corr_cnt_a), 2);

      va = ext_a(7'b1111111); va[6] = ~va[6];
      dec_a(va, 1'b0);
      chk("dec_b6_data", 32'(dec_out_data_a), 'hf);
      chk("dec_b6_syn", 32'(dec_out_syndrome_a), 7);
      chk("dec_b6_cnt", 32'(corr_cnt_a), 3);

      // Two more corrected words: counter saturates at 3.
      va = ext_a(7'b1010101); va[4] = ~va[4];
      dec_a(va, 1'b0);
      dec_a(va, 1'b0);
      chk("cnt_saturate", 32'(corr_cnt_a), 3);

      // Clear coincident with an error load: clear wins.
      va = ext_a(7'b0000111); va[0] = ~va[0];
      dec_a(va, 1'b1);
      chk("clr_priority", 32'(corr_cnt_a), 0);
      chk("clr_word_corr", 32'(dec_out_corrected_a), 1);

`ifdef HAMMING_SECDED_EN
      dec_a(8'b01010110, 1'b0);
      chk("ded_syn", 32'(dec_out_syndrome_a), 3);
      chk("ded_unc", 32'(dec_out_uncorr_a), 1);
      chk("ded_corr", 32'(dec_out_corrected_a), 0);
      chk("ded_data", 32'(dec_out_data_a), 'hb);
      chk("ded_cnt", 32'(uncorr_cnt_a), 1);
`else
      chk("sec_unc_cnt", 32'(uncorr_cnt_a), 0);
`endif

      // Instance B: out-of-range syndrome 12, held by backpressure.
      dec_out_ready_b = 0;
      vb = ext_b(9'b110011000); vb[3] = ~vb[3]; vb[7] = ~vb[7];
      @(negedge clk); dec_in_valid_b = 1; dec_in_code_b = vb;
      @(negedge clk); dec_in_valid_b = 0;
      $display("dec_b in=%0h data=%0h syn=%0d corr=%0b unc=%0b ucnt=%0d", vb, dec_out_data_b,
               dec_out_syndrome_b, dec_out_corrected_b, dec_out_uncorr_b, uncorr_cnt_b);
      chk("oor_valid", 32'(dec_out_valid_b), 1);
      chk("oor_syn", 32'(dec_out_syndrome_b), 12);
      chk("oor_unc", 32'(dec_out_uncorr_b), 1);
      chk("oor_corr", 32'(dec_out_corrected_b), 0);
      chk("oor_data", 32'(dec_out_data_b), 'h12);
      chk("oor_ucnt", 32'(uncorr_cnt_b), 1);
      chk("oor_ccnt", 32'(corr_cnt_b), 0);
      @(negedge clk);
      chk("oor_held", 32'(dec_out_valid_b), 1);
      chk("oor_in_ready", 32'(dec_in_ready_b), 0);

      // Asynchronous reset drops the held word at once.
      #2 reset = 1'b1;
      #1;
      $display("reset mid-op valid=%0b ucnt=%0d", dec_out_valid_b, uncorr_cnt_b);
      chk("rst_async_valid", 32'(dec_out_valid_b), 0);
      chk("rst_async_ucnt", 32'(uncorr_cnt_b), 0);
      chk("rst_async_data", 32'(dec_out_data_b), 0);
      @(negedge clk); reset = 1'b0; dec_out_ready_b = 1;
      @(negedge clk);
      chk("post_rst_valid", 32'(dec_out_valid_b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hamming_codec.md
# hamming_codec

Parametrised Hamming codec with separate encode and decode streaming paths, each a single registered valid/ready stage. It generalises the fixed Hamming(7,4) encoder to any data width up to 57 bits and adds syndrome decode, single-bit correction and saturating error statistics. The block sits between a data producer and a storage or link interface and protects payloads in both directions.

## Interface
- DATA_W, 4, data bits per word; legal range 1..57.
- CNT_W, 16, width of each error statistics counter.
- PAR_W, derived, smallest r with 2^r >= DATA_W + r + 1; not user-settable.
- CODE_W, derived, DATA_W + PAR_W, plus 1 when SECDED is compiled in.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- enc_in_valid / enc_in_ready  in/out  1  encoder input handshake.
- enc_in_data  in  DATA_W  word to encode.
- enc_out_valid / enc_out_ready  out/in  1  encoder output handshake.
- enc_out_code  out  CODE_W  encoded word.
- dec_in_valid / dec_in_ready  in/out  1  decoder input handshake.
- dec_in_code  in  CODE_W  received codeword.
- dec_out_valid / dec_out_ready  out/in  1  decoder output handshake.
- dec_out_data  out  DATA_W  corrected data.
- dec_out_syndrome  out  PAR_W  raw syndrome of the word.
- dec_out_corrected  out  1  a single-bit error was fixed.
- dec_out_uncorr  out  1  error detected but not correctable.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt, uncorr_cnt  out  CNT_W  saturating event counters.

## Operation
- **Code layout:**
  - Hamming position p (1-based) maps to code bit p-1, so position 1 is the LSB.
  - Parity bits sit at power-of-2 positions.
  - Data bits fill the remaining positions in ascending order, with data[0] at the lowest.
  - Parity at position 2^k is the XOR of all positions with bit k set.
- **Encoder:** computes the codeword combinationally and registers it on an input handshake.
- **Decoder syndrome:** the syndrome is the XOR, over every set code bit, of that bit's position.
  - Syndrome 0: no error.
  - Syndrome s with 1 <= s <= DATA_W+PAR_W: flip bit s-1, extract data, set corrected.
  - Syndrome s > DATA_W+PAR_W (non-full codes): set uncorr and pass the data bits unmodified.
- **Stage behaviour (both stages):**
  - One register deep; in_ready = !out_valid || out_ready.
  - A load happens on in_valid && in_ready.
  - out_valid clears on out_ready when no new load occurs.
  - Output data holds stable while out_valid && !out_ready.
- **Counters:**
  - Counters increment when a decoder word is loaded with corrected or uncorr set.
  - Counters saturate at all-ones.
  - cnt_clr has priority over a simultaneous increment.
- **Path independence:** the encode and decode paths are fully independent; simultaneous traffic on both is legal.

## Timing
- Latency is 1 cycle on each path, from the input handshake to out_valid.
- Full throughput is one word per cycle per path while out_ready is held high.
- **Reset values:** all out_valid = 0, all output data/syndrome/flags = 0, counters = 0.
  - in_ready is 1 while the stage is empty.
- Reset mid-operation drops any held word without producing an output handshake.
- Back-to-back load with simultaneous drain: the new word replaces the old in the same cycle, and out_valid stays 1.

## Configuration
- **HAMMING_SECDED_EN defined:**
  - An overall parity bit is appended as code bit CODE_W-1: the XOR of all lower code bits.
  - Decode cases:
    - Syndrome ≠ 0 with overall parity mismatch: single error, corrected.
    - Syndrome ≠ 0 with overall parity match: double error, uncorr = 1, data passed raw.
    - Syndrome = 0 with overall parity mismatch: the overall bit itself is in error; corrected = 1, data unchanged.
- **HAMMING_SECDED_EN undefined:** pure SEC. Every in-range nonzero syndrome is treated as a single error.

## Structure
- Package hamming_pkg holds:
  - Function calc_par_w(DATA_W).
  - Function is_pow2(position).
  - Data-position-to-code-index mapping functions.
- Sub-module hamming_pipe_reg: a generic WIDTH-parameterised valid/ready register stage. It is instantiated once for the encoder and once for the decoder (with data, syndrome and flags concatenated).

## Test plan
- **Encode:** DATA_W=4, no SECDED; enc_in_data=4'b1011 -> enc_out_code=7'b1010101 one cycle later.
- **Single-bit correction:** dec_in_code=7'b1000101 (bit 4 flipped) -> data 4'b1011, syndrome 3'd5, corrected=1, corr_cnt=1.
- **SECDED double error:** HAMMING_SECDED_EN, DATA_W=4; dec_in_code=8'b01010110 (bits 0,1 flipped) -> syndrome 3'd3, uncorr=1, uncorr_cnt=1.
- **Backpressure:**
  - Hold enc_out_ready=0 with two words offered -> enc_in_ready=0 after the first load and enc_out_code stable.
  - Release -> the second word appears next cycle.
- **Counter saturation:** CNT_W=2, five corrected words -> corr_cnt=3.
  - Assert cnt_clr in the same cycle as an error load -> counter reads 0.
- **Out-of-range syndrome and reset:**
  - DATA_W=5 (CODE_W=9): inject syndrome 4'd12 -> uncorr=1.
  - Assert reset while dec_out_valid=1 -> dec_out_valid=0 immediately and counters=0.
